// File: rtl/sha3_digest_axis_tx_if.sv
// -----------------------------------------------------------------------------
// sha3_digest_axis_tx_if
//
// AXI-Stream bundle carrying SHA-3 digest beats from sha3_digest_axis_tx to the
// downstream receiver.
//
// Handshake: a beat transfers on a rising clock edge where TVALID and TREADY
// are both high. Once TVALID is raised it stays high, and TDATA/TKEEP/TLAST/
// TID/TUSER stay constant, until that transfer happens (reset excepted).
// TREADY may change freely and carries no meaning while TVALID is low.
//
// Signals:
//   TVALID  master->slave  beat valid
//   TREADY  slave->master  receiver can accept a beat
//   TDATA   master->slave  DATA_WIDTH digest bits
//   TKEEP   master->slave  byte enables for TDATA
//   TLAST   master->slave  final beat of a digest
//   TID     master->slave  stream ID of the digest
//   TUSER   master->slave  user tag of the digest
// -----------------------------------------------------------------------------
interface sha3_digest_axis_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2,
  parameter int USER_WIDTH = 4
) ();

  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic                    TLAST;
  logic [ID_WIDTH-1:0]     TID;
  logic [USER_WIDTH-1:0]   TUSER;

  modport master (
    output TVALID,
    input  TREADY,
    output TDATA,
    output TKEEP,
    output TLAST,
    output TID,
    output TUSER
  );

  modport slave (
    input  TVALID,
    output TREADY,
    input  TDATA,
    input  TKEEP,
    input  TLAST,
    input  TID,
    input  TUSER
  );

endinterface

// File: rtl/sha3_digest_axis_tx.sv
// -----------------------------------------------------------------------------
// sha3_digest_axis_tx
//
// Captures the rate portion (first 512 bits) of a finished Keccak state,
// truncates it to the selected SHA-3 digest length and sends it out as an
// AXI-Stream master, least significant bits first.
//
// Ports:
//   ACLK         clock, all logic on the rising edge
//   ARESETn      synchronous active-low reset
//   state_in     Keccak state, lane (x,y) = state_in[y][x], lane i = x+5y
//   state_valid  one-cycle pulse: state_in is the final permutation result
//   digest_sel   0=SHA3-224 1=SHA3-256 2=SHA3-384 3=SHA3-512 (with state_valid)
//   id_in        stream ID, captured with state_valid
//   user_in      user tag, captured with state_valid
//   busy         high while a digest is held or being sent
//   overrun      one-cycle pulse: state_valid arrived while busy (ignored)
//   dbg_state    current FSM state (0=IDLE, 1=SEND)
//   axis         AXI-Stream master (TVALID/TREADY/TDATA/TKEEP/TLAST/TID/TUSER)
//
// Every output is a register. The registered beat fields are computed from
// the next-state values of the FSM, counter and digest register, so there is
// no combinational path from TREADY to any output.
// -----------------------------------------------------------------------------
module sha3_digest_axis_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2,
  parameter int USER_WIDTH = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [4:0][4:0][63:0]       state_in,
  input  logic                        state_valid,
  input  logic [1:0]                  digest_sel,
  input  logic [ID_WIDTH-1:0]         id_in,
  input  logic [USER_WIDTH-1:0]       user_in,
  output logic                        busy,
  output logic                        overrun,
  output logic                        dbg_state,
  sha3_digest_axis_tx_if.master       axis
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int MAX_BEATS = 512 / DATA_WIDTH;
  localparam int CNT_W     = $clog2(MAX_BEATS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Digest geometry helpers
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] digest_bytes(input logic [1:0] sel);
    logic [6:0] d;
    case (sel)
      2'd0:    d = 7'd28;
      2'd1:    d = 7'd32;
      2'd2:    d = 7'd48;
      default: d = 7'd64;
    endcase
    return d;
  endfunction

  // Index of the final beat: ceil(D/BYTES) - 1.
  function automatic logic [CNT_W-1:0] last_beat(input logic [1:0] sel);
    int n;
    n = (int'(digest_bytes(sel)) + BYTES - 1) / BYTES;
    return CNT_W'(n - 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              sel_q, sel_d;
  logic [511:0]            digest_q, digest_d;
  logic [ID_WIDTH-1:0]     tid_q, tid_d;
  logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
  logic                    tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [BYTES-1:0]        tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  // Rate lanes 0..7 laid out little-endian: flat bit n = lane n/64, bit n%64.
  logic [511:0]            state_flat;

  // Capacity lanes (and the unused halves of the state) never reach a
  // register; this reduction only marks them as intentionally dropped.
  logic                    capacity_unused;
  assign capacity_unused = ^state_in;

  always_comb begin
    state_flat = '0;
    for (int i = 0; i < 8; i++) begin
      state_flat[i*64 +: 64] = state_in[i/5][i%5];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    digest_d  = digest_q;
    tid_d     = tid_q;
    tuser_d   = tuser_q;
    // A second state arriving while a digest is in flight is dropped and
    // flagged; this includes the cycle of the final handshake.
    overrun_d = state_valid && (state_q == SEND);

    case (state_q)
      IDLE: begin
        if (state_valid) begin
          state_d  = SEND;
          cnt_d    = '0;
          sel_d    = digest_sel;
          digest_d = state_flat;
          tid_d    = id_in;
          tuser_d  = user_in;
        end
      end
      SEND: begin
        // TVALID is high for the whole of SEND, so TREADY alone marks a
        // transfer here.
        if (axis.TREADY) begin
          if (cnt_q == last_beat(sel_q)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next beat presentation, derived from next-state values
  // ---------------------------------------------------------------------------
  logic [9:0]            base_bit;
  logic [6:0]            base_byte;
  logic [6:0]            dig_bytes_d;
  logic [DATA_WIDTH-1:0] raw_beat;

  always_comb begin
    base_bit    = 10'(cnt_d) * 10'(DATA_WIDTH);
    base_byte   = 7'(cnt_d) * 7'(BYTES);
    dig_bytes_d = digest_bytes(sel_d);
    raw_beat    = digest_d[base_bit +: DATA_WIDTH];

    tvalid_d = (state_d == SEND);
    busy_d   = (state_d == SEND);
    tdata_d  = '0;
    tkeep_d  = '0;
    tlast_d  = 1'b0;

    if (state_d == SEND) begin
      tlast_d = (cnt_d == last_beat(sel_d));
      // A byte is kept only if it lies inside the digest; bytes past the
      // digest length (SHA3-224 tail on wide buses) go out as zero.
      for (int b = 0; b < BYTES; b++) begin
        if ((base_byte + 7'(b)) < dig_bytes_d) begin
          tkeep_d[b]        = 1'b1;
          tdata_d[b*8 +: 8] = raw_beat[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      digest_q  <= '0;
      tid_q     <= '0;
      tuser_q   <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      digest_q  <= digest_d;
      tid_q     <= tid_d;
      tuser_q   <= tuser_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign axis.TVALID = tvalid_q;
  assign axis.TDATA  = tdata_q;
  assign axis.TKEEP  = tkeep_q;
  assign axis.TLAST  = tlast_q;
  assign axis.TID    = tid_q;
  assign axis.TUSER  = tuser_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

endmodule
